// File: rtl/inbuf_loader_rgb565.sv
// Input-frame loader: takes a raster RGB565 stream, expands it to RGB888 and
// writes it sequentially into the frame BRAM, then pulses oDone.
module inbuf_loader_rgb565 #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272,
    parameter int DEPTH  = WIDTH * HEIGHT
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iStart,
    input  logic              iSof,
    input  logic [15:0]       iData,
    input  logic              iValid,
    output logic              oReady,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oBusy,
    output logic              oDone,
    output logic              oSofErr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, LOAD, DONE} stateT;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wrReqT;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] cnt, cntNext;
    logic              wrNext, sofErrNext, xfer;
    wrReqT             wrReq, wrReqNext;

    // Bit replication fills the low bits so full-scale stays full-scale.
    function automatic logic [23:0] expand565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    assign oReady  = (state == WAIT_SOF) || (state == LOAD);
    assign oBusy   = (state != IDLE);
    assign xfer    = iEn & iValid & oReady;
    assign oWrAddr = wrReq.addr;
    assign oWrData = wrReq.data;

    always_comb begin
        stateNext      = state;
        cntNext        = cnt;
        wrNext         = 1'b0;
        sofErrNext     = 1'b0;
        wrReqNext.addr = cnt;
        wrReqNext.data = DATA_W'(expand565(iData));
        case (state)
            IDLE: begin
                if (iStart) stateNext = WAIT_SOF;
            end
            WAIT_SOF: begin
                // Pre-SOF beats are accepted and dropped.
                if (xfer && iSof) begin
                    wrNext         = 1'b1;
                    wrReqNext.addr = '0;
                    cntNext        = (LAST == '0) ? '0 : ADDR_W'(1);
                    stateNext      = (LAST == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wrNext = 1'b1;
                    if (iSof) begin
                        // Early SOF: abandon the partial frame and restart at 0.
                        wrReqNext.addr = '0;
                        cntNext        = ADDR_W'(1);
                        sofErrNext     = 1'b1;
                    end else if (cnt == LAST) begin
                        stateNext = DONE;
                    end else begin
                        cntNext = cnt + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            cnt     <= '0;
            wrReq   <= '0;
            oWrEn   <= 1'b0;
            oDone   <= 1'b0;
            oSofErr <= 1'b0;
        end else if (!iEn) begin
            // Pulses must not stretch across disabled cycles.
            oWrEn   <= 1'b0;
            oDone   <= 1'b0;
            oSofErr <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            oWrEn   <= wrNext;
            oDone   <= (state == DONE);
            oSofErr <= sofErrNext;
            if (wrNext) wrReq <= wrReqNext;
        end
    end

endmodule

// File: tb/tb_inbuf_loader_rgb565.sv
// Directed bench for inbuf_loader_rgb565 with a 4x2 frame.
module tb_inbuf_loader_rgb565;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 24;

    logic              iClk = 1'b0;
    logic              iRst, iEn, iStart, iSof, iValid;
    logic [15:0]       iData;
    logic              oReady, oWrEn, oBusy, oDone, oSofErr;
    logic [ADDR_W-1:0] oWrAddr;
    logic [DATA_W-1:0] oWrData;

    inbuf_loader_rgb565 #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIDTH(4), .HEIGHT(2), .DEPTH(8)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iSof(iSof),
        .iData(iData), .iValid(iValid), .oReady(oReady), .oWrEn(oWrEn),
        .oWrAddr(oWrAddr), .oWrData(oWrData), .oBusy(oBusy), .oDone(oDone),
        .oSofErr(oSofErr)
    );

    always #5 iClk = ~iClk;

    int passed = 0;
    int total  = 0;

    // Write/pulse monitor, sampled on the falling edge.
    int                cyc = 0;
    logic              enPrev = 1'b0;
    logic [ADDR_W-1:0] wrAddrQ[$];
    logic [DATA_W-1:0] wrDataQ[$];
    int                wrCycQ[$];
    int                doneCnt = 0, sofErrCnt = 0, badEnWr = 0, doneCyc = 0;

    always @(posedge iClk) begin
        cyc    <= cyc + 1;
        enPrev <= iEn;
    end

    always @(negedge iClk) begin
        if (oWrEn) begin
            wrAddrQ.push_back(oWrAddr);
            wrDataQ.push_back(oWrData);
            wrCycQ.push_back(cyc);
            if (!enPrev) badEnWr++;
        end
        if (oDone) begin
            doneCnt++;
            doneCyc = cyc;
            if (!enPrev) badEnWr++;
        end
        if (oSofErr) sofErrCnt++;
    end

    function automatic logic [23:0] model(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return 24'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8)
                   | ((b << 3) | (b >> 2)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic arm();
        iEn = 1'b1; iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic s);
        int n;
        iEn = 1'b1; iValid = 1'b1; iData = d; iSof = s;
        n = 0;
        while (!oReady && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("beat_ready_timeout", 32'(n), 32'(0));
        tick();
        iValid = 1'b0; iSof = 1'b0;
    endtask

    logic [15:0] px[8];

    task automatic sendFrame();
        for (int k = 0; k < 8; k++) beat(px[k], k == 0);
    endtask

    task automatic waitDone(input string tag, input int base);
        int n;
        n = 0;
        while (doneCnt == base && n < 30) begin
            @(negedge iClk);
            #1;
            n++;
        end
        check({tag, "_done_seen"}, 32'(doneCnt - base), 32'(1));
    endtask

    task automatic checkWrites(input string tag, input int base);
        check({tag, "_wrcount"}, 32'(wrAddrQ.size() - base), 32'(8));
        for (int k = 0; k < 8; k++) begin
            if (base + k < wrAddrQ.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 32'(wrAddrQ[base+k]), 32'(k));
                check($sformatf("%s_data%0d", tag, k), 32'(wrDataQ[base+k]), 32'(model(px[k])));
            end
        end
    endtask

    initial begin
        int base, dbase, sbase, idx, n;
        logic will;
        iRst = 1'b1; iEn = 1'b0; iStart = 1'b0; iSof = 1'b0; iValid = 1'b0; iData = '0;
        repeat (3) tick();
        check("rst_ready", 32'(oReady), 0);
        check("rst_wren", 32'(oWrEn), 0);
        check("rst_addr", 32'(oWrAddr), 0);
        check("rst_data", 32'(oWrData), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_done", 32'(oDone), 0);
        check("rst_soferr", 32'(oSofErr), 0);
        iRst = 1'b0; iEn = 1'b1;
        tick();

        // Nominal frame 0x0000..0x0007.
        for (int k = 0; k < 8; k++) px[k] = 16'(k);
        base = wrAddrQ.size(); dbase = doneCnt;
        arm();
        check("arm_busy", 32'(oBusy), 1);
        check("arm_ready", 32'(oReady), 1);
        sendFrame();
        waitDone("nom", dbase);
        checkWrites("nom", base);
        check("nom_data1", 32'(wrDataQ[base+1]), 32'h000008);
        check("nom_data7", 32'(wrDataQ[base+7]), 32'h000039);
        check("nom_done_lat", 32'(doneCyc - wrCycQ[base+7]), 32'(1));
        check("nom_ready_after", 32'(oReady), 0);
        check("nom_busy_after", 32'(oBusy), 0);
        tick();
        check("nom_done_onecyc", 32'(oDone), 0);

        // Expansion corners.
        px[0] = 16'hFFFF; px[1] = 16'hF800; px[2] = 16'h07E0; px[3] = 16'h001F;
        px[4] = 16'h1234; px[5] = 16'h0000; px[6] = 16'h8410; px[7] = 16'h0821;
        base = wrAddrQ.size(); dbase = doneCnt;
        arm();
        sendFrame();
        waitDone("cor", dbase);
        checkWrites("cor", base);
        check("cor_ffff", 32'(wrDataQ[base+0]), 32'hFFFFFF);
        check("cor_f800", 32'(wrDataQ[base+1]), 32'hFF0000);
        check("cor_07e0", 32'(wrDataQ[base+2]), 32'h00FF00);
        check("cor_001f", 32'(wrDataQ[base+3]), 32'h0000FF);
        check("cor_1234", 32'(wrDataQ[base+4]), 32'h1045A5);

        // Pre-SOF garbage is consumed without writes.
        for (int k = 0; k < 8; k++) px[k] = 16'h0040 + 16'(k);
        base = wrAddrQ.size(); dbase = doneCnt;
        arm();
        repeat (3) beat(16'hAAAA, 1'b0);
        check("gar_nowrite", 32'(wrAddrQ.size() - base), 0);
        check("gar_busy", 32'(oBusy), 1);
        sendFrame();
        waitDone("gar", dbase);
        checkWrites("gar", base);

        // Early SOF after 5 pixels.
        base = wrAddrQ.size(); dbase = doneCnt; sbase = sofErrCnt;
        arm();
        for (int k = 0; k < 5; k++) beat(16'h5555 + 16'(k), k == 0);
        for (int k = 0; k < 8; k++) px[k] = 16'hC000 + 16'(k * 33);
        sendFrame();
        waitDone("esof", dbase);
        check("esof_partial_last", 32'(wrAddrQ[base+4]), 32'(4));
        check("esof_total_wr", 32'(wrAddrQ.size() - base), 32'(13));
        check("esof_soferr", 32'(sofErrCnt - sbase), 32'(1));
        checkWrites("esof", base + 5);
        tick(); tick();
        check("esof_one_done", 32'(doneCnt - dbase), 32'(1));

        // Random valid with 1/4 enable duty.
        for (int k = 0; k < 8; k++) px[k] = 16'h2100 + 16'(k * 7);
        base = wrAddrQ.size(); dbase = doneCnt;
        arm();
        idx = 0; n = 0;
        while (idx < 8 && n < 600) begin
            iEn = (n % 4 == 0); iValid = 1'($urandom_range(0, 1));
            iData = px[idx]; iSof = (idx == 0);
            will = iEn && iValid && oReady;
            tick();
            if (will) idx++;
            n++;
        end
        iEn = 1'b1; iValid = 1'b0; iSof = 1'b0;
        check("bp_all_sent", 32'(idx), 32'(8));
        waitDone("bp", dbase);
        checkWrites("bp", base);
        check("bp_no_write_en0", 32'(badEnWr), 0);

        // Reset at counter=3 while a transfer is presented.
        for (int k = 0; k < 8; k++) px[k] = 16'h7000 + 16'(k);
        arm();
        for (int k = 0; k < 3; k++) beat(px[k], k == 0);
        iValid = 1'b1; iData = 16'hFFFF; iRst = 1'b1;
        tick();
        iRst = 1'b0; iValid = 1'b0;
        check("mrst_wren", 32'(oWrEn), 0);
        check("mrst_addr", 32'(oWrAddr), 0);
        check("mrst_data", 32'(oWrData), 0);
        check("mrst_busy", 32'(oBusy), 0);
        check("mrst_ready", 32'(oReady), 0);
        check("mrst_done", 32'(oDone), 0);
        base = wrAddrQ.size(); dbase = doneCnt;
        arm();
        sendFrame();
        waitDone("mrst", dbase);
        checkWrites("mrst", base);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
